// File: rtl/obstaculo_pkg.sv
// Shared types and defaults for the obstacle spawner: FSM encoding, LFSR taps, motion constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package obstaculo_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SPAWN  = 3'd1,
      ST_MOVE   = 3'd2,
      ST_WRAP   = 3'd3,
      ST_FROZEN = 3'd4
   } estado_t;

   // Taps for x^9 + x^5 + 1 in a shift-left Fibonacci arrangement.
   localparam int LFSR_TAP_HI = 8;
   localparam int LFSR_TAP_LO = 4;

   localparam logic [8:0] Y_LIMIT_DEF    = 9'd440;
   localparam logic [2:0] SPEED_INIT_DEF = 3'd1;
   localparam logic [2:0] SPEED_MAX_DEF  = 3'd7;
   localparam logic [3:0] LEVEL_STEP_DEF = 4'd8;
   localparam logic [8:0] LFSR_SEED_DEF  = 9'h1A5;

   function automatic logic [8:0] lfsrNext(input logic [8:0] v);
      return {v[7:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
   endfunction

endpackage

// File: rtl/obstaculo_lfsr9.sv
// 9-bit maximal-length LFSR, free-running every cycle; a non-zero seed keeps it off the all-zero lock-up.
// Latency: new value every clock; seed visible the cycle after reset.
// Backpressure: none, cannot be stalled.
module obstaculo_lfsr9
   import obstaculo_pkg::*;
#(
   parameter logic [8:0] SEED = LFSR_SEED_DEF
) (
   input  logic       iClk,
   input  logic       iReset,
   output logic [8:0] oLfsr
);

   always_ff @(posedge iClk) begin
      if (iReset) oLfsr <= SEED;
      else        oLfsr <= lfsrNext(oLfsr);
   end

endmodule

// File: rtl/obstaculo_ctrl.sv
// Enemy-car motion controller: spawn/move/wrap FSM, pass score and scroll speed (OBSTACULO_ACCEL_EN enables speed-up).
// Latency: outputs registered; oEnable/oSalto pulse on the edge that acts on a SPAWN state or a MOVE frame tick.
// Backpressure: none; frame ticks outside MOVE are dropped, iColision freezes motion until iRun drops.
module obstaculo_ctrl
   import obstaculo_pkg::*;
#(
   parameter logic [8:0] Y_LIMIT    = Y_LIMIT_DEF,
   parameter logic [2:0] SPEED_INIT = SPEED_INIT_DEF,
   parameter logic [2:0] SPEED_MAX  = SPEED_MAX_DEF,
   parameter logic [3:0] LEVEL_STEP = LEVEL_STEP_DEF,
   parameter logic [8:0] LFSR_SEED  = LFSR_SEED_DEF
) (
   input  logic       iClk,
   input  logic       iReset,
   input  logic       iRun,
   input  logic       iFrameTick,
   input  logic       iColision,
   output logic [8:0] oPosicionX,
   output logic [8:0] oPosicionY,
   output logic       oEnable,
   output logic       oSalto,
   output logic [7:0] oPuntos,
   output logic [2:0] oVelocidad
);

   // A misconfigured start speed above the cap is clamped rather than exceeding it.
   localparam logic [2:0] VEL_START = (SPEED_INIT > SPEED_MAX) ? SPEED_MAX : SPEED_INIT;

   estado_t     estadoQ, estadoD;
   logic [8:0]  lfsr;
   logic [3:0]  passCnt, passD, passInc;
   logic [9:0]  yNext;
   logic        yFuera;
   logic [8:0]  xD, yD;
   logic        enD, salD;
   logic [7:0]  ptsD;
   logic [2:0]  velD;

   obstaculo_lfsr9 #(.SEED(LFSR_SEED)) uLfsr (
      .iClk   (iClk),
      .iReset (iReset),
      .oLfsr  (lfsr)
   );

   assign yNext   = {1'b0, oPosicionY} + {7'd0, oVelocidad};
   assign yFuera  = (yNext >= {1'b0, Y_LIMIT});
   assign passInc = passCnt + 4'd1;

   always_ff @(posedge iClk) begin
      if (iReset) begin
         estadoQ    <= ST_IDLE;
         oPosicionX <= '0;
         oPosicionY <= '0;
         oEnable    <= 1'b0;
         oSalto     <= 1'b0;
         oPuntos    <= '0;
         oVelocidad <= VEL_START;
         passCnt    <= '0;
      end else begin
         estadoQ    <= estadoD;
         oPosicionX <= xD;
         oPosicionY <= yD;
         oEnable    <= enD;
         oSalto     <= salD;
         oPuntos    <= ptsD;
         oVelocidad <= velD;
         passCnt    <= passD;
      end
   end

   always_comb begin
      estadoD = estadoQ;
      if (!iRun) begin
         estadoD = ST_IDLE;
      end else begin
         case (estadoQ)
            ST_IDLE:   estadoD = ST_SPAWN;
            ST_SPAWN:  estadoD = ST_MOVE;
            ST_MOVE: begin
               // Collision outranks a coincident frame tick.
               if (iColision)                 estadoD = ST_FROZEN;
               else if (iFrameTick && yFuera) estadoD = ST_WRAP;
            end
            ST_WRAP:   estadoD = ST_SPAWN;
            ST_FROZEN: estadoD = ST_FROZEN;
            default:   estadoD = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      xD    = oPosicionX;
      yD    = oPosicionY;
      enD   = 1'b0;
      salD  = 1'b0;
      ptsD  = oPuntos;
      velD  = oVelocidad;
      passD = passCnt;
      if (iRun) begin
         case (estadoQ)
            ST_IDLE: begin
               ptsD  = '0;
               passD = '0;
               velD  = VEL_START;
            end
            ST_SPAWN: begin
               xD   = lfsr;
               yD   = '0;
               enD  = 1'b1;
               salD = 1'b1;
            end
            ST_MOVE: begin
               if (!iColision && iFrameTick && !yFuera) begin
                  yD  = yNext[8:0];
                  enD = 1'b1;
               end
            end
            ST_WRAP: begin
               if (oPuntos != 8'hFF) ptsD = oPuntos + 8'd1;
               passD = (passInc == LEVEL_STEP) ? 4'd0 : passInc;
`ifdef OBSTACULO_ACCEL_EN
               if (passInc == LEVEL_STEP && oVelocidad < SPEED_MAX) velD = oVelocidad + 3'd1;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_obstaculo_ctrl.sv
// Bench for obstaculo_ctrl: vector table, directed corner sequences and a randomized run against a rule-level model.
module tb_obstaculo_ctrl;

   logic       iClk = 1'b0;
   logic       iReset, iRun, iFrameTick, iColision;
   logic [8:0] oPosicionX, oPosicionY;
   logic       oEnable, oSalto;
   logic [7:0] oPuntos;
   logic [2:0] oVelocidad;

   int checks   = 0;
   int failures = 0;

   obstaculo_ctrl dut (
      .iClk       (iClk),
      .iReset     (iReset),
      .iRun       (iRun),
      .iFrameTick (iFrameTick),
      .iColision  (iColision),
      .oPosicionX (oPosicionX),
      .oPosicionY (oPosicionY),
      .oEnable    (oEnable),
      .oSalto     (oSalto),
      .oPuntos    (oPuntos),
      .oVelocidad (oVelocidad)
   );

   always #5 iClk = ~iClk;

   // Rule-level model: flags for "in a game", "spawn due", "wrap due", "frozen"; speed derived from passes.
   bit mInGame, mSpawnNow, mWrapNow, mFrozen, mEn, mSal;
   int mX, mY, mScore, mPasses, mLfsr;

   function automatic int lfsrStep(input int v);
      return ((v << 1) & 'h1FF) | (((v >> 8) ^ (v >> 4)) & 1);
   endfunction

   function automatic int mVel(input int passes);
      int v;
`ifdef OBSTACULO_ACCEL_EN
      v = 1 + passes / 8;
      if (v > 7) v = 7;
`else
      v = 1 + 0 * passes;
`endif
      return v;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic modelReset();
      mLfsr = 'h1A5;
      mInGame = 0; mSpawnNow = 0; mWrapNow = 0; mFrozen = 0;
      mEn = 0; mSal = 0; mX = 0; mY = 0; mScore = 0; mPasses = 0;
   endtask

   task automatic modelStep(input bit run, input bit tick, input bit col);
      mEn = 0; mSal = 0;
      if (!run) begin
         mInGame = 0; mSpawnNow = 0; mWrapNow = 0; mFrozen = 0;
      end else if (!mInGame) begin
         mInGame = 1; mSpawnNow = 1; mScore = 0; mPasses = 0;
      end else if (mSpawnNow) begin
         mX = mLfsr; mY = 0; mEn = 1; mSal = 1; mSpawnNow = 0;
      end else if (mWrapNow) begin
         mPasses++;
         mScore = (mScore < 255) ? mScore + 1 : 255;
         mWrapNow = 0; mSpawnNow = 1;
      end else if (mFrozen) begin
         mFrozen = 1;
      end else if (col) begin
         mFrozen = 1;
      end else if (tick) begin
         if (mY + mVel(mPasses) >= 440) mWrapNow = 1;
         else begin mY = mY + mVel(mPasses); mEn = 1; end
      end
      mLfsr = lfsrStep(mLfsr);
   endtask

   task automatic modelCompare();
      checks++;
      if (oEnable !== mEn || oSalto !== mSal || int'(oPosicionX) != mX || int'(oPosicionY) != mY ||
          int'(oPuntos) != mScore || int'(oVelocidad) != mVel(mPasses)) begin
         failures++;
         $display("FAIL model actual en=%0b sal=%0b x=%0d y=%0d pts=%0d vel=%0d required en=%0b sal=%0b x=%0d y=%0d pts=%0d vel=%0d",
                  oEnable, oSalto, oPosicionX, oPosicionY, oPuntos, oVelocidad,
                  mEn, mSal, mX, mY, mScore, mVel(mPasses));
      end
   endtask

   task automatic cyc(input bit run, input bit tick, input bit col);
      iReset = 0; iRun = run; iFrameTick = tick; iColision = col;
      @(posedge iClk);
      modelStep(run, tick, col);
      @(negedge iClk);
      modelCompare();
   endtask

   task automatic doReset(input bit tick);
      iReset = 1; iRun = 1; iFrameTick = tick; iColision = 0;
      @(posedge iClk);
      modelReset();
      @(negedge iClk);
      modelCompare();
      iReset = 0;
   endtask

   task automatic ticks(input int n);
      repeat (n) begin cyc(1, 1, 0); cyc(1, 0, 0); end
   endtask

   // Ticks until the score reaches target, then lets the respawn happen.
   task automatic runPasses(input int target);
      int budget = 20000;
      while (int'(oPuntos) != target && budget > 0) begin
         ticks(1);
         budget--;
      end
      check("pass_target", oPuntos, target);
      cyc(1, 0, 0);
      check("pass_respawn_sal", oSalto, 1);
      check("pass_respawn_y", oPosicionY, 0);
   endtask

   typedef struct {
      bit run, tick, col;
      bit en, sal;
      int y, pts, vel;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int enCount;
      int budget;

      tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1};
      tbl[1]  = '{1, 1, 0, 1, 0, 1, 0, 1};
      tbl[2]  = '{1, 0, 0, 0, 0, 1, 0, 1};
      tbl[3]  = '{1, 1, 0, 1, 0, 2, 0, 1};
      tbl[4]  = '{1, 0, 0, 0, 0, 2, 0, 1};
      tbl[5]  = '{1, 1, 1, 0, 0, 2, 0, 1};
      tbl[6]  = '{1, 1, 0, 0, 0, 2, 0, 1};
      tbl[7]  = '{1, 0, 0, 0, 0, 2, 0, 1};
      tbl[8]  = '{0, 0, 0, 0, 0, 2, 0, 1};
      tbl[9]  = '{1, 0, 0, 0, 0, 2, 0, 1};
      tbl[10] = '{1, 0, 0, 1, 1, 0, 0, 1};
      tbl[11] = '{1, 1, 0, 1, 0, 1, 0, 1};

      // Reset values and first spawn
      doReset(0);
      check("rst_x", oPosicionX, 0);
      check("rst_y", oPosicionY, 0);
      check("rst_en", oEnable, 0);
      check("rst_sal", oSalto, 0);
      check("rst_pts", oPuntos, 0);
      check("rst_vel", oVelocidad, 1);
      cyc(1, 0, 0);
      check("idle_to_spawn_sal", oSalto, 0);
      cyc(1, 0, 0);
      check("spawn_sal", oSalto, 1);
      check("spawn_en", oEnable, 1);
      check("spawn_y", oPosicionY, 0);
      check("spawn_x", oPosicionX, lfsrStep('h1A5));
      check("spawn_vel", oVelocidad, 1);
      check("spawn_pts", oPuntos, 0);

      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].run, tbl[i].tick, tbl[i].col);
         check($sformatf("tbl%0d_en", i), oEnable, tbl[i].en);
         check($sformatf("tbl%0d_sal", i), oSalto, tbl[i].sal);
         check($sformatf("tbl%0d_y", i), oPosicionY, tbl[i].y);
         check($sformatf("tbl%0d_pts", i), oPuntos, tbl[i].pts);
         check($sformatf("tbl%0d_vel", i), oVelocidad, tbl[i].vel);
      end

      // Full pass at speed 1: 439 steps, then wrap on the 440th tick
      doReset(0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      enCount = 0;
      for (int i = 1; i <= 440; i++) begin
         cyc(1, 1, 0);
         enCount += int'(oEnable);
         check("t2_y", oPosicionY, (i < 440) ? i : 439);
         cyc(1, 0, 0);
      end
      check("t2_en_count", enCount, 439);
      check("t2_pts", oPuntos, 1);
      check("t2_sal_wrap", oSalto, 0);
      cyc(1, 0, 0);
      check("t2_respawn_sal", oSalto, 1);
      check("t2_respawn_y", oPosicionY, 0);

      // Collision with coincident tick at Y=100
      ticks(100);
      check("t4_y100", oPosicionY, 100);
      cyc(1, 1, 1);
      check("t4_col_en", oEnable, 0);
      check("t4_col_y", oPosicionY, 100);
      for (int i = 0; i < 5; i++) begin
         cyc(1, 1, 0);
         check("t4_frozen_y", oPosicionY, 100);
         check("t4_frozen_en", oEnable, 0);
      end
      cyc(0, 0, 0);
      check("t4_stop_pts_hold", oPuntos, 1);
      cyc(1, 0, 0);
      check("t4_restart_pts", oPuntos, 0);
      cyc(1, 0, 0);
      check("t4_restart_sal", oSalto, 1);
      check("t4_restart_y", oPosicionY, 0);

      // Reset mid-move at Y=200 with three passes scored
      doReset(0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      runPasses(3);
      ticks(200);
      check("t5_pre_y", oPosicionY, 200);
      check("t5_pre_pts", oPuntos, 3);
      doReset(1);
      check("t5_x", oPosicionX, 0);
      check("t5_y", oPosicionY, 0);
      check("t5_en", oEnable, 0);
      check("t5_sal", oSalto, 0);
      check("t5_pts", oPuntos, 0);
      check("t5_vel", oVelocidad, 1);
      cyc(1, 0, 0);
      check("t5_idle_sal", oSalto, 0);
      cyc(1, 0, 0);
      check("t5_lfsr_restart_x", oPosicionX, lfsrStep('h1A5));

      // Speed level
      runPasses(8);
`ifdef OBSTACULO_ACCEL_EN
      check("t3_vel_8", oVelocidad, 2);
      runPasses(56);
      check("t3_vel_56", oVelocidad, 7);
`else
      check("t3_vel_fixed", oVelocidad, 1);
`endif

      // Score saturation
      doReset(0);
      cyc(1, 0, 0);
      cyc(1, 0, 0);
      ticks(10);
      force dut.oPuntos = 8'd255;
      mScore = 255;
      cyc(1, 0, 0);
      release dut.oPuntos;
      cyc(1, 0, 0);
      check("t6_forced", oPuntos, 255);
      budget = 2000;
      while (oSalto !== 1'b1 && budget > 0) begin
         cyc(1, 1, 0);
         if (oSalto !== 1'b1) cyc(1, 0, 0);
         budget--;
      end
      check("t6_pass_done", oSalto, 1);
      check("t6_sat", oPuntos, 255);

      // Randomized run against the model
      doReset(0);
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 1499) == 0) doReset($urandom_range(0, 1) == 0);
         else cyc($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 499) == 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
